// File: rtl/pwm_motor_decoder.sv
// pwm_motor_decoder: recovers duty cycle and direction from a two-wire motor
// PWM pair (one wire active, the other low). Measures high time and period
// on a 256-ticks-per-period time base and publishes one result per period.
module pwm_motor_decoder #(
    parameter int clk_hz = 25000000,
    parameter int pwm_hz = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pwm_a,
    input  logic       pwm_b,
    output logic [7:0] duty_cycle,
    output logic       direction,
    output logic       valid,
    output logic       fault
);
    localparam int CLK_DIV_RAW = clk_hz / (256 * pwm_hz);
    localparam int CLK_DIV     = (CLK_DIV_RAW < 1) ? 1 : CLK_DIV_RAW;
    localparam int DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] PER_MIN   = 10'd250;
    localparam logic [9:0] PER_MAX   = 10'd262;
    localparam logic [9:0] CNT_SAT   = 10'd1023;
    localparam logic [9:0] LOW_LIMIT = 10'd511;
    localparam logic [9:0] HI_LIMIT  = 10'd511;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic             a_meta, a_s, b_meta, b_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    state_t           state;
    logic [9:0]       per_cnt, hi_cnt, per_inc;
    logic             p_prev, dir_cur;
    logic             p, rise, both, per_ok, low_timeout;
    logic [7:0]       hi_sat;

    // Two-flop synchronizers; they keep running regardless of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_meta <= 1'b0;
            a_s    <= 1'b0;
            b_meta <= 1'b0;
            b_s    <= 1'b0;
        end else begin
            a_meta <= pwm_a;
            a_s    <= a_meta;
            b_meta <= pwm_b;
            b_s    <= b_meta;
        end
    end

    // Tick prescaler: wraps every CLK_DIV clocks, held at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (!enable || div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick        = enable && (div_cnt == DIV_LAST);
    assign p           = a_s | b_s;
    assign rise        = p & ~p_prev;
    assign both        = a_s & b_s;
    assign per_inc     = (per_cnt == CNT_SAT) ? per_cnt : per_cnt + 10'd1;
    assign per_ok      = (per_cnt >= PER_MIN) && (per_cnt <= PER_MAX);
    // The timeout fires on the 512th tick without a rising edge
    assign low_timeout = (per_cnt >= LOW_LIMIT);
    assign hi_sat      = (hi_cnt > 10'd255) ? 8'hff : hi_cnt[7:0];

    // Measurement FSM with registered results, advanced once per tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            p_prev     <= 1'b0;
            dir_cur    <= 1'b0;
            duty_cycle <= '0;
            direction  <= 1'b0;
            valid      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                per_cnt <= '0;
                hi_cnt  <= '0;
                p_prev  <= 1'b0;
            end else if (tick) begin
                p_prev <= p;
                if (both) begin
                    // Both wires high outranks anything else on this tick
                    fault   <= 1'b1;
                    state   <= IDLE;
                    per_cnt <= '0;
                    hi_cnt  <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (rise) begin
                                state   <= HIGH;
                                hi_cnt  <= 10'd1;
                                per_cnt <= 10'd1;
                                dir_cur <= a_s;
                            end else if (p) begin
                                // Line still high after an error: the low-time
                                // timeout only counts while the line is low
                                per_cnt <= '0;
                            end else if (low_timeout) begin
                                duty_cycle <= '0;
                                valid      <= 1'b1;
                                fault      <= 1'b0;
                                per_cnt    <= '0;
                            end else begin
                                per_cnt <= per_inc;
                            end
                        end
                        HIGH: begin
                            if (!p) begin
                                state   <= LOW;
                                per_cnt <= per_inc;
                            end else if (a_s != dir_cur || hi_cnt >= HI_LIMIT) begin
                                // Active wire swapped mid-pulse, or line stuck high
                                fault   <= 1'b1;
                                state   <= IDLE;
                                per_cnt <= '0;
                                hi_cnt  <= '0;
                            end else begin
                                hi_cnt  <= hi_cnt + 10'd1;
                                per_cnt <= per_inc;
                            end
                        end
                        LOW: begin
                            if (rise) begin
                                if (per_ok) begin
                                    duty_cycle <= hi_sat;
                                    direction  <= dir_cur;
                                    valid      <= 1'b1;
                                    fault      <= 1'b0;
                                end else begin
                                    fault <= 1'b1;
                                end
                                state   <= HIGH;
                                hi_cnt  <= 10'd1;
                                per_cnt <= 10'd1;
                                dir_cur <= a_s;
                            end else if (low_timeout) begin
                                duty_cycle <= '0;
                                valid      <= 1'b1;
                                fault      <= 1'b0;
                                state      <= IDLE;
                                per_cnt    <= '0;
                            end else begin
                                per_cnt <= per_inc;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_motor_decoder.sv
// Bench for pwm_motor_decoder: a PWM driver model feeds the pair, a monitor
// logs every publish, and each test compares the log against the driver's
// programmed duty/direction and the expected 256-tick period.
module tb_pwm_motor_decoder;
    localparam int CLK_HZ  = 512;
    localparam int PWM_HZ  = 1;
    localparam int DIV     = 2;            // clocks per tick
    localparam int PER_CLK = 256 * DIV;    // clocks per nominal PWM period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       pwm_a = 1'b0;
    logic       pwm_b = 1'b0;
    logic [7:0] duty_cycle;
    logic       direction, valid, fault;

    int total = 0;
    int bad = 0;

    pwm_motor_decoder #(.clk_hz(CLK_HZ), .pwm_hz(PWM_HZ)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pwm_a(pwm_a), .pwm_b(pwm_b),
        .duty_cycle(duty_cycle), .direction(direction), .valid(valid), .fault(fault)
    );

    always #5 clk = ~clk;

    // Driver model: settings load at the period boundary
    int dcnt = 0;
    int cur_per = PER_CLK, cur_hi = 0, nxt_per = PER_CLK, nxt_hi = 0;
    bit cur_dir = 0, nxt_dir = 0, cur_on = 0, nxt_on = 0, inj_b = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (dcnt >= cur_per - 1) begin
                dcnt = 0;
                cur_per = nxt_per; cur_hi = nxt_hi; cur_dir = nxt_dir; cur_on = nxt_on;
            end else begin
                dcnt++;
            end
            pwm_a = cur_on && cur_dir && (dcnt < cur_hi);
            pwm_b = (cur_on && !cur_dir && (dcnt < cur_hi)) || inj_b;
        end
    end

    // Publish monitor
    int   cyc = 0, wide_cnt = 0;
    logic prev_valid = 1'b0;
    int   v_cyc[$];
    int   v_duty[$];
    bit   v_dir[$];
    bit   v_flt[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (valid === 1'b1) begin
                v_cyc.push_back(cyc);
                v_duty.push_back(int'(duty_cycle));
                v_dir.push_back(direction);
                v_flt.push_back(fault);
                if (prev_valid === 1'b1) wide_cnt++;
            end
            prev_valid = valid;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        v_cyc.delete(); v_duty.delete(); v_dir.delete(); v_flt.delete();
    endtask

    task automatic set_drv(input int duty, input bit dir, input bit on, input int per);
        nxt_hi = duty * DIV; nxt_dir = dir; nxt_on = on; nxt_per = per;
    endtask

    task automatic wait_dcnt(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 2 * PER_CLK; i++) begin
            @(negedge clk);
            if (dcnt == target) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0;
        run_clk(3);
        total += 4;
        if (duty_cycle !== 8'd0) begin bad++; $display("FAIL reset_duty got=%0d want=0", duty_cycle); end
        if (direction !== 1'b0) begin bad++; $display("FAIL reset_dir got=%b want=0", direction); end
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fault); end
        rst_n = 1'b1; enable = 1'b1;
        run_clk(2);
    endtask

    // Programs duty/dir, skips the transition periods, then checks a window
    task automatic test_loopback(input string tag, input int duty, input bit dir);
        set_drv(duty, dir, 1, PER_CLK);
        run_clk(2 * PER_CLK + 20);
        clear_log();
        run_clk(3 * PER_CLK);
        total++;
        if (v_cyc.size() < 2) begin
            bad++; $display("FAIL %s_count got=%0d publishes want>=2", tag, v_cyc.size());
        end
        foreach (v_cyc[i]) begin
            total++;
            if (v_duty[i] < duty - 1 || v_duty[i] > duty + 1 || v_dir[i] != dir || v_flt[i] != 0) begin
                bad++;
                $display("FAIL %s_pub[%0d] got duty=%0d dir=%0d fault=%0d want duty=%0d+-1 dir=%0d fault=0",
                         tag, i, v_duty[i], v_dir[i], v_flt[i], duty, dir);
            end
            if (i > 0) begin
                total++;
                if (v_cyc[i] - v_cyc[i-1] < PER_CLK - DIV || v_cyc[i] - v_cyc[i-1] > PER_CLK + DIV) begin
                    bad++;
                    $display("FAIL %s_interval[%0d] got=%0d clk want=%0d+-%0d",
                             tag, i, v_cyc[i] - v_cyc[i-1], PER_CLK, DIV);
                end
            end
        end
    endtask

    task automatic test_dir_b();
        bit seen;
        test_loopback("dir_b_200", 200, 0);
        set_drv(10, 0, 1, PER_CLK);
        clear_log();
        run_clk(2 * PER_CLK + 20);
        seen = 0;
        foreach (v_duty[i]) if (v_duty[i] >= 9 && v_duty[i] <= 11 && v_dir[i] == 0) seen = 1;
        total++;
        if (!seen) begin bad++; $display("FAIL dir_b_switch got %0d publishes, none with duty 9..11 dir=0", v_cyc.size()); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            int d;
            bit r;
            d = int'($urandom_range(5, 250));
            r = bit'($urandom_range(0, 1));
            test_loopback($sformatf("rand%0d", k), d, r);
        end
    endtask

    task automatic test_stuck_low();
        set_drv(100, 1, 1, PER_CLK);
        run_clk(2 * PER_CLK + 20);
        set_drv(0, 1, 0, PER_CLK);
        run_clk(PER_CLK + 8);
        clear_log();
        run_clk(4 * 2 * PER_CLK + 100);
        total++;
        if (v_cyc.size() < 3) begin bad++; $display("FAIL stuck_low_count got=%0d want>=3", v_cyc.size()); end
        foreach (v_cyc[i]) begin
            total++;
            if (v_duty[i] != 0 || v_dir[i] != 1 || v_flt[i] != 0) begin
                bad++;
                $display("FAIL stuck_low_pub[%0d] got duty=%0d dir=%0d fault=%0d want 0/1/0",
                         i, v_duty[i], v_dir[i], v_flt[i]);
            end
            if (i > 0) begin
                total++;
                if (v_cyc[i] - v_cyc[i-1] < 2 * PER_CLK - DIV || v_cyc[i] - v_cyc[i-1] > 2 * PER_CLK + DIV) begin
                    bad++;
                    $display("FAIL stuck_low_interval[%0d] got=%0d want=%0d", i, v_cyc[i] - v_cyc[i-1], 2 * PER_CLK);
                end
            end
        end
    endtask

    task automatic test_both_high();
        bit ok;
        set_drv(128, 1, 1, PER_CLK);
        run_clk(2 * PER_CLK + 20);
        wait_dcnt(100, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL both_high_wait driver phase not reached"); end
        inj_b = 1; clear_log();
        run_clk(3 * DIV);
        inj_b = 0;
        run_clk(30);
        total++;
        if (fault !== 1'b1) begin bad++; $display("FAIL both_high_fault got=%b want=1", fault); end
        run_clk(620);
        total += 2;
        if (v_cyc.size() != 0) begin bad++; $display("FAIL both_high_novalid got=%0d publishes want=0", v_cyc.size()); end
        if (fault !== 1'b1) begin bad++; $display("FAIL both_high_fault_hold got=%b want=1", fault); end
        run_clk(600);
        total += 2;
        if (v_cyc.size() < 1 || v_duty[$] < 127 || v_duty[$] > 129 || v_flt[$] != 0) begin
            bad++; $display("FAIL both_high_resume got %0d publishes, want good duty 127..129", v_cyc.size());
        end
        if (fault !== 1'b0) begin bad++; $display("FAIL both_high_clear got=%b want=0", fault); end
    endtask

    task automatic test_double_freq();
        set_drv(64, 1, 1, PER_CLK / 2);
        run_clk(PER_CLK + 300);
        clear_log();
        run_clk(3000);
        total += 2;
        if (v_cyc.size() != 0) begin bad++; $display("FAIL double_freq_novalid got=%0d publishes want=0", v_cyc.size()); end
        if (fault !== 1'b1) begin bad++; $display("FAIL double_freq_fault got=%b want=1", fault); end
        set_drv(128, 1, 1, PER_CLK);
        run_clk(3 * PER_CLK + 20);
        total++;
        if (fault !== 1'b0 || v_cyc.size() < 1) begin
            bad++; $display("FAIL double_freq_recover got fault=%b publishes=%0d want fault=0 publishes>=1", fault, v_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_dcnt(60, ok);
        total++;
        if (!ok || direction !== 1'b1 || duty_cycle < 8'd127) begin
            bad++; $display("FAIL reset_mid_pre got dir=%b duty=%0d want dir=1 duty~128", direction, duty_cycle);
        end
        #2 rst_n = 1'b0;
        #1;
        total += 4;
        if (duty_cycle !== 8'd0) begin bad++; $display("FAIL reset_mid_duty got=%0d want=0", duty_cycle); end
        if (direction !== 1'b0) begin bad++; $display("FAIL reset_mid_dir got=%b want=0", direction); end
        if (valid !== 1'b0) begin bad++; $display("FAIL reset_mid_valid got=%b want=0", valid); end
        if (fault !== 1'b0) begin bad++; $display("FAIL reset_mid_fault got=%b want=0", fault); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        run_clk(PER_CLK);
        total++;
        if (v_cyc.size() != 0) begin bad++; $display("FAIL reset_mid_early got=%0d publishes want=0", v_cyc.size()); end
        run_clk(2 * PER_CLK);
        total++;
        if (v_cyc.size() < 1 || v_duty[$] < 127 || v_duty[$] > 129 || v_dir[$] != 1) begin
            bad++; $display("FAIL reset_mid_resume got %0d publishes, want duty 127..129 dir=1", v_cyc.size());
        end
    endtask

    task automatic test_enable();
        bit ok;
        logic [7:0] d0;
        logic r0, f0;
        wait_dcnt(300, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL enable_wait driver phase not reached"); end
        d0 = duty_cycle; r0 = direction; f0 = fault;
        enable = 1'b0;
        clear_log();
        run_clk(1000);
        total += 2;
        if (v_cyc.size() != 0) begin bad++; $display("FAIL enable_novalid got=%0d publishes want=0", v_cyc.size()); end
        if (duty_cycle !== d0 || direction !== r0 || fault !== f0) begin
            bad++; $display("FAIL enable_hold got %0d/%b/%b want %0d/%b/%b", duty_cycle, direction, fault, d0, r0, f0);
        end
        enable = 1'b1;
        run_clk(3 * PER_CLK);
        total++;
        if (v_cyc.size() < 1 || v_duty[$] < 127 || v_duty[$] > 129 || v_dir[$] != 1 || fault !== 1'b0) begin
            bad++; $display("FAIL enable_resume got %0d publishes, want duty 127..129 dir=1 fault=0", v_cyc.size());
        end
    endtask

    task automatic test_pulse_width();
        total++;
        if (wide_cnt != 0) begin bad++; $display("FAIL valid_width got %0d multi-cycle pulses want=0", wide_cnt); end
    endtask

    initial begin
        test_reset();
        test_loopback("loop_a_128", 128, 1);
        test_dir_b();
        test_random();
        test_stuck_low();
        test_both_high();
        test_double_freq();
        test_reset_mid();
        test_enable();
        test_pulse_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
